// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file slice.
package regfile_pkg;

    typedef enum logic [1:0] {
        BYP_NONE = 2'd0,
        BYP_COMB = 2'd1,
        BYP_REG  = 2'd2
    } bypass_mode_e;

    localparam int REG_X0 = 0;

    // Address width for a file of n registers; never narrower than one bit.
    function automatic int aw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by allocation, cleared by writeback, set wins on collision.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int AW     = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NWRITE-1:0]      we_i,
    input  logic [NWRITE*AW-1:0]   wa_i,
    input  logic                   alloc_en_i,
    input  logic [AW-1:0]          alloc_rd_i,
    input  logic [NREAD*AW-1:0]    rs_i,
    output logic [NREAD-1:0]       busy_o
);

    logic [NREGS-1:0] busy_q, busy_d;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != AW'(REG_X0)) && (32'(a) < NREGS);
    endfunction

    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NWRITE; p++) begin
            if (we_i[p] && addr_ok(wa_i[p*AW +: AW]))
                busy_d[wa_i[p*AW +: AW]] = 1'b0;
        end
        // Applied after the clears so a new producer supersedes the retiring one.
        if (alloc_en_i && addr_ok(alloc_rd_i))
            busy_d[alloc_rd_i] = 1'b1;
        busy_d[REG_X0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_lookup
        logic [AW-1:0] a;
        assign a         = rs_i[i*AW +: AW];
        assign busy_o[i] = addr_ok(a) ? busy_q[a] : 1'b0;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with selectable write bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = int'(BYP_REG),
    localparam int AW    = aw_f(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*AW-1:0]      rs,
    output logic [NREAD*XLEN-1:0]    rdata,
    output logic [NREAD-1:0]         busy,
    input  logic [NWRITE-1:0]        we,
    input  logic [NWRITE*AW-1:0]     wa,
    input  logic [NWRITE*XLEN-1:0]   wd,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_rd
);

    if (NREGS < 2 || NREGS > 32) begin : g_bad_nregs
        $error("regfile_mp: NREGS must be 2..32");
    end
    if (NREAD < 1 || NREAD > 6) begin : g_bad_nread
        $error("regfile_mp: NREAD must be 1..6");
    end
    if (NWRITE < 1 || NWRITE > 3) begin : g_bad_nwrite
        $error("regfile_mp: NWRITE must be 1..3");
    end
    if (BYPASS < 0 || BYPASS > 2) begin : g_bad_bypass
        $error("regfile_mp: BYPASS must be 0..2");
    end

    localparam bit MASK_BUSY = (BYPASS == int'(BYP_COMB));

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != AW'(REG_X0)) && (32'(a) < NREGS);
    endfunction

    logic [AW-1:0]   wa_a [NWRITE];
    logic [XLEN-1:0] wd_a [NWRITE];

    for (genvar p = 0; p < NWRITE; p++) begin : g_wunpack
        assign wa_a[p] = wa[p*AW +: AW];
        assign wd_a[p] = wd[p*XLEN +: XLEN];
    end

    // Storage; x0 is reset to zero and never written.
    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            // Ascending order: the highest-indexed port to the same address lands last.
            for (int p = 0; p < NWRITE; p++) begin
                if (we[p] && addr_ok(wa_a[p])) regs_q[wa_a[p]] <= wd_a[p];
            end
        end
    end

    // Bypass source per write port, chosen by mode; the read mux is mode-agnostic.
    logic [NWRITE-1:0] bsel_vld;
    logic [AW-1:0]     bsel_wa [NWRITE];
    logic [XLEN-1:0]   bsel_wd [NWRITE];

    if (BYPASS == int'(BYP_COMB)) begin : g_comb
        for (genvar p = 0; p < NWRITE; p++) begin : g_p
            assign bsel_vld[p] = we[p] & ~reset;
            assign bsel_wa[p]  = wa_a[p];
            assign bsel_wd[p]  = wd_a[p];
        end
    end else if (BYPASS == int'(BYP_REG)) begin : g_reg
        logic [NWRITE-1:0] byp_vld_q;
        logic [AW-1:0]     byp_wa_q [NWRITE];
        logic [XLEN-1:0]   byp_wd_q [NWRITE];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                byp_vld_q <= '0;
                for (int p = 0; p < NWRITE; p++) begin
                    byp_wa_q[p] <= '0;
                    byp_wd_q[p] <= '0;
                end
            end else begin
                for (int p = 0; p < NWRITE; p++) begin
                    byp_vld_q[p] <= (we[p] === 1'b1) && (wa_a[p] != AW'(REG_X0));
                    byp_wa_q[p]  <= wa_a[p];
                    byp_wd_q[p]  <= wd_a[p];
                end
            end
        end

        for (genvar p = 0; p < NWRITE; p++) begin : g_p
            assign bsel_vld[p] = byp_vld_q[p];
            assign bsel_wa[p]  = byp_wa_q[p];
            assign bsel_wd[p]  = byp_wd_q[p];
        end
    end else begin : g_none
        for (genvar p = 0; p < NWRITE; p++) begin : g_p
            assign bsel_vld[p] = 1'b0;
            assign bsel_wa[p]  = '0;
            assign bsel_wd[p]  = '0;
        end
    end

    logic [NREAD-1:0] sb_busy;

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE),
        .AW     (AW)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .we_i       (we),
        .wa_i       (wa),
        .alloc_en_i (alloc_en),
        .alloc_rd_i (alloc_rd),
        .rs_i       (rs),
        .busy_o     (sb_busy)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic            hit;
        logic [XLEN-1:0] d;

        assign a = rs[i*AW +: AW];

        always_comb begin
            hit = 1'b0;
            d   = addr_ok(a) ? regs_q[a] : '0;
            for (int p = 0; p < NWRITE; p++) begin
                if (addr_ok(a) && bsel_vld[p] && bsel_wa[p] == a) begin
                    hit = 1'b1;
                    d   = bsel_wd[p];
                end
            end
        end

        assign rdata[i*XLEN +: XLEN] = d;
        // Same-cycle write-through already delivers the value, so the reader need not stall.
        assign busy[i] = sb_busy[i] & ~(hit & MASK_BUSY);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench: three regfile_mp instances (one per bypass mode) against one reference model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rs;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic        alloc_en;
    logic [4:0]  alloc_rd;

    logic [63:0] rd_n, rd_c, rd_r;
    logic [1:0]  bz_n, bz_c, bz_r;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(0)) u_none (
        .clk(clk), .reset(reset), .rs(rs), .rdata(rd_n), .busy(bz_n),
        .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_rd(alloc_rd));

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1)) u_comb (
        .clk(clk), .reset(reset), .rs(rs), .rdata(rd_c), .busy(bz_c),
        .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_rd(alloc_rd));

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(2)) u_reg (
        .clk(clk), .reset(reset), .rs(rs), .rdata(rd_r), .busy(bz_r),
        .we(we), .wa(wa), .wd(wd), .alloc_en(alloc_en), .alloc_rd(alloc_rd));

    // Reference state: architectural values, busy flags, and last edge's write requests.
    logic [31:0] mem [32];
    bit          bsy [32];
    bit          pv;
    logic [1:0]  pwe;
    logic [4:0]  pwa [2];
    logic [31:0] pwd [2];

    string mn [3] = '{"none", "comb", "reg"};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            mem[r] = '0;
            bsy[r] = 1'b0;
        end
        pv = 1'b0;
    endtask

    // Returns {busy, data} expected on a read of address a in the given mode.
    function automatic logic [32:0] model_rd(input int mode, input logic [4:0] a);
        logic [31:0] d;
        logic        b;
        if (reset || a == 5'd0) return 33'd0;
        d = mem[a];
        b = bsy[a];
        if (mode == 1) begin
            for (int p = 0; p < 2; p++)
                if (we[p] === 1'b1 && wa[p*5 +: 5] == a) begin
                    d = wd[p*32 +: 32];
                    b = 1'b0;
                end
        end else if (mode == 2 && pv) begin
            for (int p = 0; p < 2; p++)
                if (pwe[p] === 1'b1 && pwa[p] == a) d = pwd[p];
        end
        return {b, d};
    endfunction

    task automatic settle();
        logic [63:0] rdv;
        logic [1:0]  bzv;
        logic [32:0] e;
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            rdv = (m == 0) ? rd_n : (m == 1) ? rd_c : rd_r;
            bzv = (m == 0) ? bz_n : (m == 1) ? bz_c : bz_r;
            for (int i = 0; i < 2; i++) begin
                e = model_rd(m, rs[i*5 +: 5]);
                chk($sformatf("%s_rd%0d_x%0d", mn[m], i, rs[i*5 +: 5]), rdv[i*32 +: 32], e[31:0]);
                chk($sformatf("%s_bz%0d_x%0d", mn[m], i, rs[i*5 +: 5]), {31'd0, bzv[i]}, {31'd0, e[32]});
            end
        end
    endtask

    task automatic tick();
        logic [4:0] a;
        @(posedge clk);
        if (reset) begin
            pv = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                a = wa[p*5 +: 5];
                if (we[p] === 1'b1) begin
                    if (a != 5'd0) mem[a] = wd[p*32 +: 32];
                    bsy[a] = 1'b0;
                end
            end
            if (alloc_en) bsy[alloc_rd] = 1'b1;
            bsy[0] = 1'b0;
            pv  = 1'b1;
            pwe = we;
            for (int p = 0; p < 2; p++) begin
                pwa[p] = wa[p*5 +: 5];
                pwd[p] = wd[p*32 +: 32];
            end
        end
        #1;
    endtask

    task automatic idle();
        we = 2'b00; wa = '0; wd = '0; alloc_en = 1'b0; alloc_rd = '0;
    endtask

    function automatic logic [4:0] rnd_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k < 8)  return 5'(k);
        if (k == 8) return 5'd31;
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        reset = 1'b1;
        rs = '0;
        idle();
        model_clear();
        pwe = '0;
        settle();
        tick();
        settle();
        tick();
        reset = 1'b0;

        // Every register reads zero and idle after reset; x0 ignores writes.
        for (int r = 1; r < 32; r++) begin
            rs = {5'(r), 5'(r)};
            settle();
            tick();
        end
        we = 2'b01; wa = '0; wd = {32'd0, 32'hDEAD}; rs = '0;
        settle();
        tick();
        idle();
        settle();
        chk("t1_x0", rd_n[31:0], 32'd0);
        tick();

        // Write visibility: array the next cycle, comb same cycle, highest port wins.
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'h1234}; rs = {5'd0, 5'd5};
        settle();
        chk("t2_none_same", rd_n[31:0], 32'd0);
        tick();
        idle();
        settle();
        chk("t2_none_next", rd_n[31:0], 32'h1234);
        tick();

        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'hB, 32'hA}; rs = {5'd0, 5'd7};
        settle();
        chk("t3_comb_same", rd_c[31:0], 32'hB);
        tick();
        idle();
        settle();
        chk("t3_comb_arr", rd_c[31:0], 32'hB);
        chk("t3_none_arr", rd_n[31:0], 32'hB);
        tick();

        // Delayed bypass, then an unknown write enable.
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h55};
        tick();
        idle();
        rs = {5'd3, 5'd0};
        settle();
        chk("t4_reg_byp", rd_r[63:32], 32'h55);
        tick();
        we = 2'bx0; wa = {5'd3, 5'd3}; wd = {32'h99, 32'h99};
        tick();
        idle();
        settle();
        tick();

        // Scoreboard: set, set-beats-clear, clear.
        alloc_en = 1'b1; alloc_rd = 5'd9;
        tick();
        idle();
        rs = {5'd0, 5'd9};
        settle();
        chk("t5_busy_set", {31'd0, bz_n[0]}, 32'd1);
        alloc_en = 1'b1; alloc_rd = 5'd9; we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'h77};
        tick();
        idle();
        settle();
        chk("t5_busy_keep", {31'd0, bz_n[0]}, 32'd1);
        chk("t5_data", rd_n[31:0], 32'h77);
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'h77};
        tick();
        idle();
        settle();
        chk("t5_busy_clr", {31'd0, bz_n[0]}, 32'd0);
        tick();

        // Reset mid-stream with x4 busy and a write to x4 pending.
        we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'd0, 32'h44};
        alloc_en = 1'b1; alloc_rd = 5'd4;
        tick();
        alloc_en = 1'b0;
        wd = {32'd0, 32'h45};
        rs = {5'd4, 5'd4};
        #2;
        reset = 1'b1;
        model_clear();
        settle();
        chk("t6_comb_in_rst", rd_c[31:0], 32'd0);
        tick();
        reset = 1'b0;
        idle();
        settle();
        chk("t6_reg_after", rd_r[31:0], 32'd0);
        chk("t6_busy_after", {31'd0, bz_n[0]}, 32'd0);
        tick();

        // Randomised traffic on a narrow address range to force collisions.
        for (int c = 0; c < 400; c++) begin
            rs       = {rnd_addr(), rnd_addr()};
            we       = 2'($urandom_range(0, 3));
            wa       = {rnd_addr(), rnd_addr()};
            wd       = {$urandom, $urandom};
            alloc_en = 1'($urandom_range(0, 1));
            alloc_rd = rnd_addr();
            settle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
